// File: rtl/alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_cmd_ctrl
// Brief    : Builds (cmd, A, B) frames from the RX byte stream, fires the ALU,
//            returns the 16-bit result to TX low byte first.
//            Optional macro ALU_TIMEOUT_EN adds an ALU_WAIT watchdog with Err.
// Revision : 1.0 - initial release
// ============================================================================
module alu_cmd_ctrl #(
  parameter int         DATA_WIDTH = 8,
  parameter int         OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter logic [3:0] HDR        = 4'hA,
  parameter int         TIMEOUT    = 32
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_P_DATA,
  input  logic                  RX_D_VLD,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  ALU_Valid,
  output logic [DATA_WIDTH-1:0] TX_P_DATA,
  output logic                  TX_D_VLD,
  input  logic                  TX_Busy,
  output logic                  Busy,
  output logic                  Err
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_A    = 3'd1,
    GET_B    = 3'd2,
    ALU_GO   = 3'd3,
    ALU_WAIT = 3'd4,
    TX_LO    = 3'd5,
    TX_HI    = 3'd6
  } state_t;

  if (OUT_WIDTH != 2 * DATA_WIDTH || TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_param
    $error("alu_cmd_ctrl: OUT_WIDTH must be 2*DATA_WIDTH and TIMEOUT in 1..63");
  end

  state_t                r_state;
  state_t                w_next;
  logic [DATA_WIDTH-1:0] r_alu_a;
  logic [DATA_WIDTH-1:0] r_alu_b;
  logic [3:0]            r_alu_fun;
  logic [OUT_WIDTH-1:0]  r_res;
  logic [DATA_WIDTH-1:0] r_tx_data;
  logic                  r_tx_vld;
  logic                  w_ld_fun;
  logic                  w_ld_a;
  logic                  w_ld_b;
  logic                  w_ld_res;
  logic                  w_tx_set;
  logic                  w_tx_clr;

`ifdef ALU_TIMEOUT_EN
  localparam logic [5:0] C_TERM = 6'(TIMEOUT - 1);
  logic [5:0] r_wait_cnt;
  logic       r_err;
  logic       w_timeout;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_ld_fun = 1'b0;
    w_ld_a   = 1'b0;
    w_ld_b   = 1'b0;
    w_ld_res = 1'b0;
    w_tx_set = 1'b0;
    w_tx_clr = 1'b0;
`ifdef ALU_TIMEOUT_EN
    w_timeout = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        // Bytes without the header nibble are silently discarded.
        if (RX_D_VLD && RX_P_DATA[DATA_WIDTH-1 -: 4] == HDR) begin
          w_ld_fun = 1'b1;
          w_next   = GET_A;
        end
      end
      GET_A: begin
        if (RX_D_VLD) begin
          w_ld_a = 1'b1;
          w_next = GET_B;
        end
      end
      GET_B: begin
        if (RX_D_VLD) begin
          w_ld_b = 1'b1;
          w_next = ALU_GO;
        end
      end
      ALU_GO: w_next = ALU_WAIT;
      ALU_WAIT: begin
        // A valid result on the terminal count takes priority over the timeout.
        if (ALU_Valid) begin
          w_ld_res = 1'b1;
          w_next   = TX_LO;
        end
`ifdef ALU_TIMEOUT_EN
        else if (r_wait_cnt == C_TERM) begin
          w_timeout = 1'b1;
          w_next    = IDLE;
        end
`endif
      end
      TX_LO, TX_HI: begin
        // Present only once TX is idle; TX_Busy seen high while presenting means accepted.
        if (!r_tx_vld) begin
          w_tx_set = !TX_Busy;
        end else if (TX_Busy) begin
          w_tx_clr = 1'b1;
          w_next   = (r_state == TX_LO) ? TX_HI : IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_fun <= '0;
      r_res     <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
    end else begin
      if (w_ld_fun) r_alu_fun <= RX_P_DATA[3:0];
      if (w_ld_a)   r_alu_a   <= RX_P_DATA;
      if (w_ld_b)   r_alu_b   <= RX_P_DATA;
      if (w_ld_res) r_res     <= ALU_OUT;
      if (w_tx_set) begin
        r_tx_vld  <= 1'b1;
        r_tx_data <= (r_state == TX_LO) ? r_res[DATA_WIDTH-1:0]
                                        : r_res[OUT_WIDTH-1:DATA_WIDTH];
      end else if (w_tx_clr) begin
        r_tx_vld <= 1'b0;
      end
    end
  end

`ifdef ALU_TIMEOUT_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == ALU_WAIT) ? r_wait_cnt + 6'd1 : 6'd0;
      r_err      <= w_timeout;
    end
  end

  assign Err = r_err;
`else
  assign Err = 1'b0;
`endif

  assign ALU_A     = r_alu_a;
  assign ALU_B     = r_alu_b;
  assign ALU_FUN   = r_alu_fun;
  assign ALU_EN    = (r_state == ALU_GO);
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign Busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_cmd_ctrl
// Brief    : Directed self-checking bench for alu_cmd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_cmd_ctrl;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  ALU_A;
  logic [7:0]  ALU_B;
  logic [3:0]  ALU_FUN;
  logic        ALU_EN;
  logic [15:0] ALU_OUT = '0;
  logic        ALU_Valid = 1'b0;
  logic [7:0]  TX_P_DATA;
  logic        TX_D_VLD;
  logic        TX_Busy = 1'b0;
  logic        Busy;
  logic        Err;

  int n_pass  = 0;
  int n_total = 0;

  alu_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
    .ALU_OUT(ALU_OUT), .ALU_Valid(ALU_Valid),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_Busy(TX_Busy),
    .Busy(Busy), .Err(Err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  // Waits (bounded) for a presented byte, checks it, holds it unaccepted, then accepts.
  task automatic get_tx(input string tag, input logic [7:0] exp, input int hold);
    int k = 0;
    while (TX_D_VLD !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    check({tag, " vld"}, 16'(TX_D_VLD), 16'd1);
    check({tag, " data"}, 16'(TX_P_DATA), 16'(exp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, " hold vld"}, 16'(TX_D_VLD), 16'd1);
      check({tag, " hold data"}, 16'(TX_P_DATA), 16'(exp));
    end
    TX_Busy = 1'b1;
    tick();
    check({tag, " vld cleared"}, 16'(TX_D_VLD), 16'd0);
    TX_Busy = 1'b0;
  endtask

  // Drives the frame and returns the result one cycle into ALU_WAIT.
  task automatic run_frame(input string tag, input logic [7:0] cmd, input logic [7:0] a,
                           input logic [7:0] b, input logic [15:0] res);
    send_byte(cmd);
    send_byte(a);
    send_byte(b);
    check({tag, " en"}, 16'(ALU_EN), 16'd1);
    check({tag, " A"}, 16'(ALU_A), 16'(a));
    check({tag, " B"}, 16'(ALU_B), 16'(b));
    check({tag, " FUN"}, 16'(ALU_FUN), 16'(cmd[3:0]));
    tick();
    check({tag, " en pulse"}, 16'(ALU_EN), 16'd0);
    ALU_OUT   = res;
    ALU_Valid = 1'b1;
    tick();
    ALU_Valid = 1'b0;
  endtask

  initial begin
    // Reset
    #2;
    check("reset busy", 16'(Busy), 16'd0);
    check("reset en", 16'(ALU_EN), 16'd0);
    check("reset txvld", 16'(TX_D_VLD), 16'd0);
    check("reset txdata", 16'(TX_P_DATA), 16'd0);
    check("reset A", 16'(ALU_A), 16'd0);
    check("reset err", 16'(Err), 16'd0);
    tick();
    tick();
    RST = 1'b0;
    tick();

    // Add: minimum latency, first byte one cycle after capture
    run_frame("add", 8'hA0, 8'h0F, 8'h03, 16'h0012);
    check("add lat vld early", 16'(TX_D_VLD), 16'd0);
    tick();
    check("add lat vld", 16'(TX_D_VLD), 16'd1);
    get_tx("add lo", 8'h12, 0);
    get_tx("add hi", 8'h00, 0);
    check("add busy done", 16'(Busy), 16'd0);

    // Multiply with a 5-cycle held presentation
    run_frame("mul", 8'hA2, 8'hC8, 8'hC8, 16'h9C40);
    get_tx("mul lo", 8'h40, 5);
    get_tx("mul hi", 8'h9C, 5);
    check("mul busy done", 16'(Busy), 16'd0);

    // Bad header is dropped
    send_byte(8'h52);
    check("badhdr busy", 16'(Busy), 16'd0);
    send_byte(8'h0F);
    check("badhdr busy2", 16'(Busy), 16'd0);
    check("badhdr en", 16'(ALU_EN), 16'd0);
    check("badhdr fun", 16'(ALU_FUN), 16'd2);
    run_frame("sub", 8'hA1, 8'h0F, 8'h03, 16'h000C);
    get_tx("sub lo", 8'h0C, 0);
    get_tx("sub hi", 8'h00, 0);

    // TX already busy on entering TX_LO
    TX_Busy = 1'b1;
    run_frame("txbusy", 8'hA0, 8'h0F, 8'h03, 16'h0012);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("txbusy withheld", 16'(TX_D_VLD), 16'd0);
    end
    TX_Busy = 1'b0;
    tick();
    check("txbusy rise", 16'(TX_D_VLD), 16'd1);
    get_tx("txbusy lo", 8'h12, 0);
    get_tx("txbusy hi", 8'h00, 0);

    // Asynchronous reset during ALU_WAIT
    send_byte(8'hA3);
    send_byte(8'h55);
    send_byte(8'hAA);
    tick();
    check("rst pre busy", 16'(Busy), 16'd1);
    RST = 1'b1;
    #1;
    check("rst busy", 16'(Busy), 16'd0);
    check("rst A", 16'(ALU_A), 16'd0);
    check("rst B", 16'(ALU_B), 16'd0);
    check("rst fun", 16'(ALU_FUN), 16'd0);
    check("rst txvld", 16'(TX_D_VLD), 16'd0);
    tick();
    RST = 1'b0;
    ALU_OUT   = 16'hBEEF;
    ALU_Valid = 1'b1;
    tick();
    ALU_Valid = 1'b0;
    tick();
    check("late valid busy", 16'(Busy), 16'd0);
    check("late valid txvld", 16'(TX_D_VLD), 16'd0);
    run_frame("post rst", 8'hA1, 8'h0F, 8'h03, 16'h000C);
    get_tx("post rst lo", 8'h0C, 0);
    get_tx("post rst hi", 8'h00, 0);
    check("post rst idle", 16'(Busy), 16'd0);
    check("err quiet", 16'(Err), 16'd0);

`ifdef ALU_TIMEOUT_EN
    // Watchdog: no ALU_Valid, Err after 32 ALU_WAIT cycles
    send_byte(8'hA0);
    send_byte(8'h01);
    send_byte(8'h02);
    tick();
    for (int i = 1; i < 32; i++) begin
      tick();
      check("to wait err", 16'(Err), 16'd0);
      check("to wait busy", 16'(Busy), 16'd1);
    end
    tick();
    check("to err", 16'(Err), 16'd1);
    check("to busy", 16'(Busy), 16'd0);
    tick();
    check("to err pulse", 16'(Err), 16'd0);
    check("to no tx", 16'(TX_D_VLD), 16'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
